// File: rtl/coef_reload_ctrl.sv
// FIR coefficient reload sequencer: resets the FIR core, streams one ROM bank over the reload
// channel, waits a settle gap and then issues the config word. Macro COEF_RELOAD_TIMEOUT_EN adds a stall watchdog.
module coef_reload_ctrl #(
    parameter int COEF_NUM          = 192,
    parameter int COEF_W            = 16,
    parameter int LENGTH_rst        = 5,
    parameter int DELAY_LENGTH_conf = 200,
    parameter int TIMEOUT           = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        bank_sel,
    output logic [9:0]        coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    output logic [COEF_W-1:0] rel_tdata,
    output logic              rel_tvalid,
    input  logic              rel_tready,
    output logic              rel_tlast,
    output logic [7:0]        conf_tdata,
    output logic              conf_tvalid,
    input  logic              conf_tready,
    output logic              fir_aresetn,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        dbg_state
);

    if (COEF_NUM < 2 || COEF_NUM > 256) begin : g_bad_coef_num
        $error("coef_reload_ctrl: COEF_NUM out of range 2..256");
    end
    if (LENGTH_rst < 2 || LENGTH_rst > 255) begin : g_bad_length_rst
        $error("coef_reload_ctrl: LENGTH_rst out of range 2..255");
    end
    if (DELAY_LENGTH_conf < 1 || DELAY_LENGTH_conf > 65535) begin : g_bad_delay
        $error("coef_reload_ctrl: DELAY_LENGTH_conf out of range 1..65535");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("coef_reload_ctrl: TIMEOUT out of range 1..65535");
    end

    localparam logic [7:0]  LAST_IDX = 8'(COEF_NUM - 1);
    localparam logic [15:0] RST_LAST = 16'(LENGTH_rst - 1);
    localparam logic [15:0] GAP_LAST = 16'(DELAY_LENGTH_conf - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FIR_RST = 3'd1,
        FETCH   = 3'd2,
        SEND    = 3'd3,
        GAP     = 3'd4,
        CONFIG  = 3'd5,
        FIN     = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          bank_q, bank_d;
    logic [7:0]          idx_q, idx_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [9:0]          addr_q, addr_d;
    logic [COEF_W-1:0]   rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;
    logic                rlast_q, rlast_d;
    logic [7:0]          cdata_q, cdata_d;
    logic                cvalid_q, cvalid_d;
    logic                rstn_q, rstn_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                wd_fire;

`ifdef COEF_RELOAD_TIMEOUT_EN
    localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

    logic [15:0] wd_q, wd_d;
    logic        err_q;

    // Counts consecutive stalled cycles while offering data; any non-stalled cycle clears it.
    always_comb begin
        wd_d = '0;
        if ((state_q == SEND && !rel_tready) || (state_q == CONFIG && !conf_tready)) begin
            wd_d = wd_q + 16'd1;
        end
    end

    assign wd_fire = (wd_d == TO_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= wd_fire;
        end
    end

    assign err = err_q;
`else
    assign wd_fire = 1'b0;
    assign err     = 1'b0;
`endif

    // Both channels follow AXI-Stream rules: once valid is raised the payload (and coef_addr)
    // is frozen until the cycle where valid && ready, and ready alone never changes state.
    always_comb begin
        state_d  = state_q;
        bank_d   = bank_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        rdata_d  = rdata_q;
        rvalid_d = rvalid_q;
        rlast_d  = rlast_q;
        cdata_d  = cdata_q;
        cvalid_d = cvalid_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    bank_d  = bank_sel;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = FIR_RST;
                end
            end
            FIR_RST: begin
                if (cnt_q == RST_LAST) begin
                    cnt_d   = '0;
                    addr_d  = {bank_q, idx_q};
                    state_d = FETCH;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            FETCH: begin
                // First cycle presents the address, second cycle sees the ROM word.
                if (cnt_q == 16'd0) begin
                    cnt_d = 16'd1;
                end else begin
                    cnt_d    = '0;
                    rdata_d  = coef_data;
                    rlast_d  = (idx_q == LAST_IDX);
                    rvalid_d = 1'b1;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (rel_tready) begin
                    rvalid_d = 1'b0;
                    if (rlast_q) begin
                        rlast_d = 1'b0;
                        cnt_d   = '0;
                        state_d = GAP;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        addr_d  = {bank_q, idx_q + 8'd1};
                        state_d = FETCH;
                    end
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d    = '0;
                    cdata_d  = {6'b0, bank_q};
                    cvalid_d = 1'b1;
                    state_d  = CONFIG;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            CONFIG: begin
                if (conf_tready) begin
                    cvalid_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (wd_fire) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
            cvalid_d = 1'b0;
            cnt_d    = '0;
            done_d   = 1'b0;
            state_d  = IDLE;
        end

        rstn_d = (state_d != FIR_RST);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            bank_q   <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            cdata_q  <= '0;
            cvalid_q <= 1'b0;
            rstn_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bank_q   <= bank_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            rlast_q  <= rlast_d;
            cdata_q  <= cdata_d;
            cvalid_q <= cvalid_d;
            rstn_q   <= rstn_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign coef_addr   = addr_q;
    assign rel_tdata   = rdata_q;
    assign rel_tvalid  = rvalid_q;
    assign rel_tlast   = rlast_q;
    assign conf_tdata  = cdata_q;
    assign conf_tvalid = cvalid_q;
    assign fir_aresetn = rstn_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_coef_reload_ctrl.sv
// Bench for coef_reload_ctrl: table-driven reload runs against a scoreboard of expected
// beats/config words, plus hand-written reset-in-GAP and config-stall sequences.
module tb_coef_reload_ctrl;
  localparam int COEF_NUM = 192;
  localparam int COEF_W = 16;
  localparam int LEN_RST = 5;
  localparam int DELAY = 200;
  localparam int TB_TIMEOUT = 16;
  localparam int BW = 1 + 10 + COEF_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [1:0] bank_sel = 2'd0;
  logic [9:0] coef_addr;
  logic [COEF_W-1:0] coef_data = '0;
  logic [COEF_W-1:0] rel_tdata;
  logic rel_tvalid, rel_tlast;
  logic rel_tready = 1'b0;
  logic [7:0] conf_tdata;
  logic conf_tvalid;
  logic conf_tready = 1'b0;
  logic fir_aresetn, busy, done, err;
  logic [2:0] dbg_state;

  coef_reload_ctrl #(
    .COEF_NUM(COEF_NUM), .COEF_W(COEF_W), .LENGTH_rst(LEN_RST),
    .DELAY_LENGTH_conf(DELAY), .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bank_sel(bank_sel),
    .coef_addr(coef_addr), .coef_data(coef_data),
    .rel_tdata(rel_tdata), .rel_tvalid(rel_tvalid), .rel_tready(rel_tready), .rel_tlast(rel_tlast),
    .conf_tdata(conf_tdata), .conf_tvalid(conf_tvalid), .conf_tready(conf_tready),
    .fir_aresetn(fir_aresetn), .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / ROM model ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [COEF_W-1:0] rom_f(input logic [9:0] a);
    return {a[5:0], a} ^ 16'hC3A5;
  endfunction

  always @(posedge clk) coef_data <= rom_f(coef_addr);

  initial begin
    #5_000_000;
    $display("FAIL global_timeout act=running req=finished");
    $fatal(1, "bench time limit");
  end

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%0h req=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [BW-1:0] exp_q[$];
  logic [7:0] exp_conf_q[$];
  int beats, dones, errs, rst_lows, conf_first_cyc, last_cyc, done_cyc, err_cyc;
  bit conf_seen;
  bit stall_q = 1'b0;
  logic [BW-1:0] held_q = '0;

  task automatic clear_stats();
    beats = 0; dones = 0; errs = 0; rst_lows = 0; conf_seen = 0;
    conf_first_cyc = 0; last_cyc = 0; done_cyc = 0; err_cyc = 0;
  endtask

  always @(negedge clk) begin : mon
    logic [BW-1:0] cur;
    logic [BW-1:0] e;
    logic [7:0] ec;
    cur = {rel_tlast, coef_addr, rel_tdata};
    if (rst_n) begin
      if (rel_tvalid && stall_q) check("stall_stable", 32'(cur), 32'(held_q));
      if (rel_tvalid && rel_tready) begin
        if (exp_q.size() == 0) check("unexpected_beat", 32'(cur), 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          check("beat", 32'(cur), 32'(e));
        end
        beats++;
        if (rel_tlast) last_cyc = cyc;
      end
      stall_q = rel_tvalid && !rel_tready;
      held_q = cur;
      if (conf_tvalid && !conf_seen) begin
        conf_seen = 1;
        conf_first_cyc = cyc;
      end
      if (conf_tvalid && conf_tready) begin
        if (exp_conf_q.size() == 0) check("unexpected_conf", 32'(conf_tdata), 32'hFFFF_FFFF);
        else begin
          ec = exp_conf_q.pop_front();
          check("conf_tdata", 32'(conf_tdata), 32'(ec));
        end
      end
      if (done) begin dones++; done_cyc = cyc; end
      if (err) begin errs++; err_cyc = cyc; end
      if (!fir_aresetn) begin
        rst_lows++;
        if (!busy) check("busy_in_fir_rst", 32'(busy), 32'd1);
      end
    end else begin
      stall_q = 1'b0;
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beats(input logic [1:0] bank);
    for (int i = 0; i < COEF_NUM; i++) begin
      logic [7:0] ix;
      ix = 8'(i);
      exp_q.push_back({(i == COEF_NUM - 1), bank, ix, rom_f({bank, ix})});
    end
  endtask

  typedef struct {
    logic [1:0] bank;
    bit rnd_ready;
    bit restart;
    logic [7:0] exp_conf;
    int exp_len;
  } vec_t;

  vec_t vecs[4];

  task automatic run_seq(input vec_t v);
    int t0;
    int zrun;
    clear_stats();
    push_beats(v.bank);
    exp_conf_q.push_back(v.exp_conf);
    conf_tready = 1'b1;
    rel_tready = 1'b1;
    start = 1'b1;
    bank_sel = v.bank;
    t0 = cyc;
    tick();
    start = 1'b0;
    bank_sel = ~v.bank;
    zrun = 0;
    for (int n = 0; n < 5000 && dones == 0; n++) begin
      if (v.rnd_ready) begin
        rel_tready = (zrun >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
        zrun = rel_tready ? 0 : zrun + 1;
      end else begin
        rel_tready = 1'b1;
      end
      if (v.restart && n == 300) begin
        start = 1'b1;
        bank_sel = v.bank + 2'd1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    tick();
    tick();
    check("done_count", 32'(dones), 32'd1);
    check("beat_count", 32'(beats), 32'(COEF_NUM));
    check("beats_left", 32'(exp_q.size()), 32'd0);
    check("conf_left", 32'(exp_conf_q.size()), 32'd0);
    check("fir_rst_len", 32'(rst_lows), 32'(LEN_RST));
    check("err_count", 32'(errs), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    if (v.exp_len != 0) begin
      check("done_latency", 32'(done_cyc - t0), 32'(v.exp_len));
      // DELAY gap cycles sit strictly between the last-beat cycle and the CONFIG cycle.
      check("conf_after_last", 32'(conf_first_cyc - last_cyc), 32'(DELAY + 1));
    end
    exp_q.delete();
    exp_conf_q.delete();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int c;
    vec_t again;
    vecs[0] = '{bank: 2'd2, rnd_ready: 1'b0, restart: 1'b0, exp_conf: 8'h02, exp_len: LEN_RST + 3 * COEF_NUM + DELAY + 2};
    vecs[1] = '{bank: 2'd1, rnd_ready: 1'b1, restart: 1'b1, exp_conf: 8'h01, exp_len: 0};
    vecs[2] = '{bank: 2'd3, rnd_ready: 1'b0, restart: 1'b1, exp_conf: 8'h03, exp_len: 783};
    vecs[3] = '{bank: 2'd0, rnd_ready: 1'b1, restart: 1'b0, exp_conf: 8'h00, exp_len: 0};
    clear_stats();

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_rel_tvalid", 32'(rel_tvalid), 32'd0);
    check("rst_rel_tlast", 32'(rel_tlast), 32'd0);
    check("rst_rel_tdata", 32'(rel_tdata), 32'd0);
    check("rst_conf_tvalid", 32'(conf_tvalid), 32'd0);
    check("rst_conf_tdata", 32'(conf_tdata), 32'd0);
    check("rst_coef_addr", 32'(coef_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_fir_aresetn", 32'(fir_aresetn), 32'd1);
    check("rst_state", 32'(dbg_state), 32'd0);
    tick();
    rst_n = 1'b1;
    rel_tready = 1'b1;
    conf_tready = 1'b1;
    repeat (3) tick();
    check("idle_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 4; i++) run_seq(vecs[i]);

    // Reset during GAP: the burst completes, config must never appear.
    clear_stats();
    push_beats(2'd1);
    rel_tready = 1'b1;
    conf_tready = 1'b1;
    start = 1'b1;
    bank_sel = 2'd1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 2000 && beats < COEF_NUM; n++) tick();
    repeat (50) tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("async_busy", 32'(busy), 32'd0);
    check("async_fir_aresetn", 32'(fir_aresetn), 32'd1);
    check("async_conf_tvalid", 32'(conf_tvalid), 32'd0);
    check("async_coef_addr", 32'(coef_addr), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (250) tick();
    check("gap_rst_beats", 32'(beats), 32'(COEF_NUM));
    check("gap_rst_conf_seen", 32'(conf_seen), 32'd0);
    check("gap_rst_done", 32'(dones), 32'd0);
    exp_q.delete();
    again = '{bank: 2'd2, rnd_ready: 1'b0, restart: 1'b0, exp_conf: 8'h02, exp_len: 783};
    run_seq(again);

    // Config channel stalled
    clear_stats();
    push_beats(2'd3);
    rel_tready = 1'b1;
    conf_tready = 1'b0;
    start = 1'b1;
    bank_sel = 2'd3;
    tick();
    start = 1'b0;
    for (int n = 0; n < 2000 && !conf_seen; n++) tick();
    check("stall_conf_reached", 32'(conf_seen), 32'd1);
    check("stall_conf_tdata", 32'(conf_tdata), 32'h03);
    c = conf_first_cyc;
`ifdef COEF_RELOAD_TIMEOUT_EN
    for (int n = 0; n < 100 && errs == 0; n++) tick();
    check("to_err_seen", 32'(errs), 32'd1);
    check("to_err_delay", 32'(err_cyc - c), 32'(TB_TIMEOUT));
    check("to_busy_next", 32'(busy), 32'd0);
    check("to_conf_dropped", 32'(conf_tvalid), 32'd0);
    repeat (5) tick();
    check("to_no_done", 32'(dones), 32'd0);
    check("to_err_pulse", 32'(errs), 32'd1);
`else
    begin
      int held;
      held = 0;
      for (int n = 0; n < 100; n++) begin
        tick();
        if (conf_tvalid && conf_tdata == 8'h03) held++;
      end
      check("hold_conf_tvalid", 32'(held), 32'd100);
      check("hold_no_err", 32'(errs), 32'd0);
      check("hold_no_done", 32'(dones), 32'd0);
      exp_conf_q.push_back(8'h03);
      conf_tready = 1'b1;
      for (int n = 0; n < 10 && dones == 0; n++) tick();
      tick();
      check("hold_done", 32'(dones), 32'd1);
      check("hold_conf_left", 32'(exp_conf_q.size()), 32'd0);
      check("hold_busy_after", 32'(busy), 32'd0);
    end
`endif
    check("stall_beats", 32'(beats), 32'(COEF_NUM));
    exp_q.delete();
    exp_conf_q.delete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/coef_reload_ctrl.md
COEF_RELOAD_CTRL -- requirements
Module: coef_reload_ctrl

Interface
REQ-001 SHALL have parameter COEF_NUM, default 192: coefficients per reload burst, range 2..256.
REQ-002 SHALL have parameter COEF_W, default 16: coefficient width.
REQ-003 SHALL have parameter LENGTH_rst, default 5: FIR reset low time in cycles, range 2..255.
REQ-004 SHALL have parameter DELAY_LENGTH_conf, default 200: cycles from last reload beat to config valid, range 1..65535.
REQ-005 SHALL have parameter TIMEOUT, default 1024: stall watchdog limit in cycles, range 1..65535.
REQ-006 SHALL have port clk, input, 1: single clock for all logic.
REQ-007 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1: single-cycle request to begin a reload sequence.
REQ-009 SHALL have port bank_sel, input, 2: coefficient bank, sampled with start.
REQ-010 SHALL have port coef_addr, output, 10: {bank, index[7:0]} to synchronous ROM.
REQ-011 SHALL have port coef_data, input, COEF_W: ROM read data, 1-cycle latency.
REQ-012 SHALL have ports rel_tdata (output, COEF_W), rel_tvalid (output, 1), rel_tready (input, 1) and rel_tlast (output, 1): FIR reload AXI-Stream channel.
REQ-013 SHALL have ports conf_tdata (output, 8), conf_tvalid (output, 1) and conf_tready (input, 1): FIR config AXI-Stream channel.
REQ-014 SHALL have port fir_aresetn, output, 1: active-low FIR core reset.
REQ-015 SHALL have ports busy (output, 1), done (output, 1) and err (output, 1): status, with done and err as single-cycle pulses.

Function
REQ-016 SHALL implement FSM states IDLE, FIR_RST, FETCH, SEND, GAP, CONFIG and FIN.
REQ-017 IDLE: busy=0; start=1 latches bank_sel and sets index=0 -> FIR_RST next cycle.
REQ-018 start while busy=1 SHALL be ignored, with no queuing.
REQ-019 FIR_RST: fir_aresetn=0 for exactly LENGTH_rst cycles -> FETCH.
REQ-020 FETCH: lasts exactly 2 cycles; coef_addr={bank,index} registered on entry; coef_data captured into rel_tdata on the 2nd cycle -> SEND.
REQ-021 SEND: rel_tvalid=1; rel_tlast=1 iff index==COEF_NUM-1; rel_tdata, rel_tlast and coef_addr SHALL stay stable until rel_tready=1.
REQ-022 Handshake in SEND, not last beat: index+1 -> FETCH; rel_tvalid=0 on the following cycle.
REQ-023 Handshake in SEND, last beat: -> GAP; index SHALL NOT wrap past COEF_NUM-1.
REQ-024 GAP: counts DELAY_LENGTH_conf cycles; rel_tvalid=0 -> CONFIG.
REQ-025 CONFIG: conf_tvalid=1 and conf_tdata={6'b0,bank}, held until conf_tready=1 -> FIN.
REQ-026 FIN: done=1 for exactly one cycle -> IDLE.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 Throughput SHALL be one coefficient per 3 cycles at best (2 FETCH + 1 SEND); the minimum sequence length is LENGTH_rst + 3*COEF_NUM + DELAY_LENGTH_conf + 2 cycles.
REQ-029 rel_tready or conf_tready asserted outside SEND/CONFIG SHALL have no effect.

Reset
REQ-030 rst_n=0 SHALL force, asynchronously, state=IDLE, index=0 and counters=0.
REQ-031 rst_n=0 SHALL force all outputs to their reset values: rel_tvalid=0, rel_tlast=0, rel_tdata=0, conf_tvalid=0, conf_tdata=0, coef_addr=0, busy=0, done=0, err=0, fir_aresetn=1.
REQ-032 Reset mid-sequence SHALL abandon the burst; the next start SHALL restart from FIR_RST with index 0.

Configuration
REQ-033 The stall watchdog SHALL be compiled in by macro COEF_RELOAD_TIMEOUT_EN.
REQ-034 With COEF_RELOAD_TIMEOUT_EN: a counter increments each cycle spent in SEND with rel_tready=0 or in CONFIG with conf_tready=0, and clears on handshake.
REQ-035 With COEF_RELOAD_TIMEOUT_EN: when the counter reaches TIMEOUT, the block SHALL drop all valids, pulse err=1 for one cycle and return to IDLE; done SHALL NOT pulse.
REQ-036 Without COEF_RELOAD_TIMEOUT_EN: the counter SHALL be absent, err SHALL be tied to 0, and the block SHALL wait indefinitely for ready.

Verification
REQ-037 start, bank=2, rel_tready and conf_tready tied 1 -> fir_aresetn low 5 cycles; 192 beats read from addresses 0x200..0x2BF; rel_tlast only on beat 191; conf_tvalid 200 cycles after last beat with conf_tdata=0x02; done at cycle 5+576+200+2.
REQ-038 rel_tready toggling pseudo-randomly -> rel_tdata, rel_tlast and coef_addr stable during every stall; beat count and order exactly 192, unchanged.
REQ-039 start pulsed again during SEND -> ignored; exactly one done; bank_sel change mid-sequence has no effect.
REQ-040 rst_n low during GAP, then start -> conf_tvalid never asserted for the first run; second run completes a full sequence from index 0.
REQ-041 With COEF_RELOAD_TIMEOUT_EN and TIMEOUT=16, conf_tready held 0 -> err pulse 16 cycles after CONFIG entry, busy=0 next cycle, no done; without the macro -> conf_tvalid held indefinitely.
